// File: rtl/debounce_multi_pkg.sv
// Shared constants and types for the multi-channel debouncer and the legacy
// single-bit debouncer.
package debounce_multi_pkg;

  localparam int CNT_W_DEF = 23;
  localparam int WAIT_SIM  = 10;
  localparam int WAIT_HW   = 4999999;

  // Next-cycle event conditions produced by one channel
  typedef struct packed {
    logic rise;
    logic fall;
  } chan_evt_t;

  function automatic logic evt_any(input chan_evt_t evt);
    return evt.rise | evt.fall;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter, registered
// clean level and one-cycle rise/fall pulses.
module debounce_chan
  import debounce_multi_pkg::*;
#(
  parameter int              CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] WAIT = CNT_W'(WAIT_SIM)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tick,
  input  logic      sig_in,
  output logic      sig_out,
  output logic      rise,
  output logic      fall,
  output chan_evt_t evt_nxt
);

  localparam logic [CNT_W-1:0] WAIT_M1 = WAIT - CNT_W'(1);

  logic             r_sync0;
  logic             r_sync1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_out_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Qualification rules in priority order; the counter is capped at WAIT-1
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_out_nxt  = r_out;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    if (r_sync1 == r_out) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (r_sync0 != r_sync1) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (!tick) begin
      w_cnt_nxt = r_cnt;
    end else if (r_cnt == WAIT_M1) begin
      w_out_nxt  = r_sync1;
      w_cnt_nxt  = {CNT_W{1'b0}};
      w_rise_nxt = r_sync1;
      w_fall_nxt = ~r_sync1;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync0 <= sig_in;
      r_sync1 <= r_sync0;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign sig_out      = r_out;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign evt_nxt.rise = w_rise_nxt;
  assign evt_nxt.fall = w_fall_nxt;

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels sharing one clock and one tick enable,
// with a registered any-channel change flag aligned to the pulses.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int               N     = 4,
  parameter int               CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] WAIT  = CNT_W'(WAIT_SIM)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [N-1:0] sigIn,
  output logic [N-1:0] sigOut,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         anyChange
);

  logic [N-1:0] w_evt;
  logic         r_any;

  for (genvar g = 0; g < N; g++) begin : g_chan
    chan_evt_t w_chan_evt;

    debounce_chan #(
      .CNT_W (CNT_W),
      .WAIT  (WAIT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .sig_in  (sigIn[g]),
      .sig_out (sigOut[g]),
      .rise    (rise[g]),
      .fall    (fall[g]),
      .evt_nxt (w_chan_evt)
    );

    assign w_evt[g] = evt_any(w_chan_evt);
  end

  // Built from next-cycle conditions so it lands on the same edge as the pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_evt;
    end
  end

  assign anyChange = r_any;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios followed by
// randomized stimulus, all checked against a behavioural reference model.
module tb_debounce_multi;

  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int WAITV = 4;

  logic         clk;
  logic         rst;
  logic         tick;
  logic [N-1:0] sigIn;
  logic [N-1:0] sigOut;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         anyChange;

  int n_checks;
  int n_pass;

  // Reference model state
  logic [N-1:0] m_s0, m_s1, m_out, m_rise, m_fall;
  logic         m_any;
  int           m_q[N];

  debounce_multi #(
    .N     (N),
    .CNT_W (CNT_W),
    .WAIT  (8'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .sigIn     (sigIn),
    .sigOut    (sigOut),
    .rise      (rise),
    .fall      (fall),
    .anyChange (anyChange)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // A channel changes once its synchronised level has differed from the
  // output, without glitching, for WAIT tick-high edges in a row.
  task automatic model_edge();
    if (rst) begin
      m_s0 = '0; m_s1 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
      for (int i = 0; i < N; i++) m_q[i] = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s1[i] != m_out[i] && m_s0[i] == m_s1[i]) begin
          if (tick) begin
            m_q[i] = m_q[i] + 1;
            if (m_q[i] == WAITV) begin
              m_out[i]  = m_s1[i];
              m_rise[i] = m_s1[i];
              m_fall[i] = !m_s1[i];
              m_q[i]    = 0;
            end
          end
        end else begin
          m_q[i] = 0;
        end
      end
      m_s1  = m_s0;
      m_s0  = sigIn;
      m_any = (m_rise != '0) || (m_fall != '0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("sigOut", 32'(sigOut), 32'(m_out));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("anyChange", 32'(anyChange), 32'(m_any));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_s0 = '0; m_s1 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
    for (int i = 0; i < N; i++) m_q[i] = 0;
    rst   = 1'b1;
    tick  = 1'b1;
    sigIn = 4'hF;
    @(negedge clk);

    // Reset with inputs high
    steps(2);
    chk("reset_out", 32'(sigOut), 32'h0);
    rst   = 1'b0;
    sigIn = 4'h0;
    step();
    chk("post_reset_out", 32'(sigOut), 32'h0);
    steps(3);

    // Clean press on channel 0
    sigIn[0] = 1'b1;
    steps(5);
    chk("press_early", 32'(sigOut[0]), 32'h0);
    step();
    chk("press_edge6", 32'(sigOut[0]), 32'h1);
    chk("press_rise", 32'(rise), 32'h1);
    chk("press_any", 32'(anyChange), 32'h1);
    step();
    chk("press_rise_gone", 32'(rise), 32'h0);

    // Short pulse on channel 1 must be rejected
    sigIn[1] = 1'b1;
    steps(3);
    sigIn[1] = 1'b0;
    steps(8);
    chk("glitch_out", 32'(sigOut[1]), 32'h0);

    // Dropout during qualification restarts the count
    sigIn[1] = 1'b1;
    steps(4);
    sigIn[1] = 1'b0;
    step();
    sigIn[1] = 1'b1;
    steps(5);
    chk("dropout_early", 32'(sigOut[1]), 32'h0);
    step();
    chk("dropout_late", 32'(sigOut[1]), 32'h1);

    // Simultaneous release on channels 2 and 3
    sigIn[3:2] = 2'b11;
    steps(8);
    sigIn[3:2] = 2'b00;
    steps(5);
    chk("rel_early", 32'(sigOut[3:2]), 32'h3);
    step();
    chk("rel_fall", 32'(fall[3:2]), 32'h3);
    chk("rel_any", 32'(anyChange), 32'h1);
    step();
    chk("rel_any_once", 32'(anyChange), 32'h0);

    // Tick every third cycle on a channel 0 release
    sigIn[0] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick = (k % 3 == 0) ? 1'b1 : 1'b0;
      step();
    end
    chk("tick_done", 32'(sigOut[0]), 32'h0);
    tick = 1'b1;

    // Reset mid-count forfeits the partial count
    sigIn = 4'h1;
    steps(4);
    rst = 1'b1;
    step();
    chk("midrst_out", 32'(sigOut), 32'h0);
    rst = 1'b0;
    steps(5);
    chk("midrst_early", 32'(sigOut[0]), 32'h0);
    step();
    chk("midrst_late", 32'(sigOut[0]), 32'h1);

    // Randomized phase
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) sigIn[i] = ~sigIn[i];
      tick = (k < 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
      rst  = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
